// File: rtl/mdu_pkg.sv
// Shared MULTSel encodings, FSM states and default latencies for the multiply/divide unit.
// Pure declarations: no latency, no backpressure.
package mdu_pkg;

    localparam logic [2:0] MD_MFHI  = 3'b000;
    localparam logic [2:0] MD_MTHI  = 3'b001;
    localparam logic [2:0] MD_MFLO  = 3'b010;
    localparam logic [2:0] MD_MTLO  = 3'b011;
    localparam logic [2:0] MD_MULT  = 3'b100;
    localparam logic [2:0] MD_MULTU = 3'b101;
    localparam logic [2:0] MD_DIV   = 3'b110;
    localparam logic [2:0] MD_DIVU  = 3'b111;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W_DEF       = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_t;

    // mult/multu/div/divu all carry funct[3]=1 in the MULTSel encoding.
    function automatic logic is_md_start(input logic en, input logic [2:0] sel);
        return en & sel[2];
    endfunction

    function automatic logic is_div(input logic [2:0] sel);
        return sel[1];
    endfunction

endpackage

// File: rtl/mdu_if.sv
// E-stage <-> multiply/divide unit signal bundle; master is the pipeline side, slave is the MDU.
// The abort wire only exists when MDU_ABORT_EN is defined.
interface mdu_if;

    logic        md_en;
    logic [2:0]  md_sel;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        d_is_md;
    logic        busy;
    logic        stall_req;
    logic [31:0] rd_val;
    logic [31:0] hi;
    logic [31:0] lo;
`ifdef MDU_ABORT_EN
    logic        abort;

    modport master (
        output md_en, md_sel, rs_val, rt_val, d_is_md, abort,
        input  busy, stall_req, rd_val, hi, lo
    );

    modport slave (
        input  md_en, md_sel, rs_val, rt_val, d_is_md, abort,
        output busy, stall_req, rd_val, hi, lo
    );
`else
    modport master (
        output md_en, md_sel, rs_val, rt_val, d_is_md,
        input  busy, stall_req, rd_val, hi, lo
    );

    modport slave (
        input  md_en, md_sel, rs_val, rt_val, d_is_md,
        output busy, stall_req, rd_val, hi, lo
    );
`endif

endinterface

// File: rtl/mdu_arith.sv
// Combinational 32x32 multiply and divide (signed/unsigned) producing a {hi,lo} pair.
// Zero latency, no backpressure; valid=0 flags a divide by zero so the caller keeps HI/LO.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        valid
);

    logic signed [63:0] a_s64;
    logic signed [63:0] b_s64;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic        [31:0] quot_u;
    logic        [31:0] rem_u;
    logic               div_zero;
    logic               div_ovf;

    assign a_s64  = {{32{a[31]}}, a};
    assign b_s64  = {{32{b[31]}}, b};
    assign prod_s = a_s64 * b_s64;
    assign prod_u = {32'd0, a} * {32'd0, b};

    assign a_s      = a;
    assign b_s      = b;
    assign div_zero = (b == 32'd0);
    // INT_MIN / -1 does not fit; the architectural result is pinned explicitly.
    assign div_ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    // Divisor is forced to 1 on the illegal cases so the operators never see them.
    logic signed [31:0] b_s_safe;
    logic        [31:0] b_u_safe;
    assign b_s_safe = (div_zero || div_ovf) ? 32'sd1 : b_s;
    assign b_u_safe = div_zero ? 32'd1 : b;

    assign quot_s = a_s / b_s_safe;
    assign rem_s  = a_s % b_s_safe;
    assign quot_u = a / b_u_safe;
    assign rem_u  = a % b_u_safe;

    always_comb begin
        hi    = 32'd0;
        lo    = 32'd0;
        valid = 1'b1;
        case (op)
            MD_MULT: begin
                hi = prod_s[63:32];
                lo = prod_s[31:0];
            end
            MD_MULTU: begin
                hi = prod_u[63:32];
                lo = prod_u[31:0];
            end
            MD_DIV: begin
                if (div_zero) begin
                    valid = 1'b0;
                end else if (div_ovf) begin
                    hi = 32'd0;
                    lo = 32'h8000_0000;
                end else begin
                    hi = rem_s;
                    lo = quot_s;
                end
            end
            MD_DIVU: begin
                if (div_zero) begin
                    valid = 1'b0;
                end else begin
                    hi = rem_u;
                    lo = quot_u;
                end
            end
            default: begin
                valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_sequencer.sv
// HI/LO owner: runs mult/div over MULT_CYCLES/DIV_CYCLES, serves mthi/mtlo/mfhi/mflo, raises stall_req.
// Result committed MULT/DIV_CYCLES edges after the start edge; optional MDU_ABORT_EN adds an abort input.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic  clk,
    input  logic  reset,
    mdu_if.slave  md
);

    md_state_t         state;
    logic [CNT_W-1:0]  cnt;
    logic              busy_q;
    logic [31:0]       hi_q;
    logic [31:0]       lo_q;
    logic [31:0]       pend_hi;
    logic [31:0]       pend_lo;
    logic              pend_vld;

    logic [31:0]       arith_hi;
    logic [31:0]       arith_lo;
    logic              arith_vld;
    logic              abort_in;
    logic              start;

    mdu_arith u_arith (
        .op    (md.md_sel),
        .a     (md.rs_val),
        .b     (md.rt_val),
        .hi    (arith_hi),
        .lo    (arith_lo),
        .valid (arith_vld)
    );

`ifdef MDU_ABORT_EN
    assign abort_in = md.abort;
`else
    assign abort_in = 1'b0;
`endif

    // md_en while RUN is a hazard-unit violation and is dropped by gating on IDLE.
    assign start = is_md_start(md.md_en, md.md_sel) && (state == ST_IDLE) && !abort_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            busy_q   <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            pend_hi  <= 32'd0;
            pend_lo  <= 32'd0;
            pend_vld <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pend_hi  <= arith_hi;
                        pend_lo  <= arith_lo;
                        pend_vld <= arith_vld;
                        cnt      <= is_div(md.md_sel) ? CNT_W'(DIV_CYCLES - 1)
                                                      : CNT_W'(MULT_CYCLES - 1);
                        busy_q   <= 1'b1;
                        state    <= ST_RUN;
                    end else if (md.md_en && (md.md_sel == MD_MTHI)) begin
                        hi_q <= md.rs_val;
                    end else if (md.md_en && (md.md_sel == MD_MTLO)) begin
                        lo_q <= md.rs_val;
                    end
                end
                ST_RUN: begin
                    if (abort_in) begin
                        state    <= ST_IDLE;
                        busy_q   <= 1'b0;
                        cnt      <= '0;
                        pend_hi  <= 32'd0;
                        pend_lo  <= 32'd0;
                        pend_vld <= 1'b0;
                    end else if (cnt == '0) begin
                        // Divide by zero runs the full period but leaves HI/LO alone.
                        if (pend_vld) begin
                            hi_q <= pend_hi;
                            lo_q <= pend_lo;
                        end
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign md.busy      = busy_q;
    assign md.hi        = hi_q;
    assign md.lo        = lo_q;
    assign md.stall_req = md.d_is_md & (busy_q | is_md_start(md.md_en, md.md_sel));

    always_comb begin
        md.rd_val = 32'd0;
        if (md.md_sel == MD_MFHI) begin
            md.rd_val = hi_q;
        end else if (md.md_sel == MD_MFLO) begin
            md.rd_val = lo_q;
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Bench for mdu_sequencer: directed scenarios plus randomized ops against an arithmetic reference model.
// Abort scenarios are compiled in only when MDU_ABORT_EN is defined.
module tb_mdu_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    always #5 clk = ~clk;

    mdu_if bus ();

    mdu_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.md_en   = 1'b0;
        bus.md_sel  = 3'b000;
        bus.rs_val  = 32'd0;
        bus.rt_val  = 32'd0;
        bus.d_is_md = 1'b0;
`ifdef MDU_ABORT_EN
        bus.abort   = 1'b0;
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic start_op(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
        bus.md_en  = 1'b1;
        bus.md_sel = sel;
        bus.rs_val = a;
        bus.rt_val = b;
        tick();
        bus.md_en  = 1'b0;
        bus.md_sel = 3'b000;
    endtask

    // Start an op and count busy cycles, bounded; lands on the first cycle after busy drops.
    task automatic run_op(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b,
                          output int n);
        start_op(sel, a, b);
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
    endtask

    // Reference: {valid, hi, lo} straight from the arithmetic definitions.
    function automatic logic [64:0] model_op(input logic [2:0] sel, input logic [31:0] a,
                                             input logic [31:0] b);
        int sa, sb, q, r;
        longint p;
        logic [63:0] pu;
        logic [31:0] qu, ru;
        sa = a;
        sb = b;
        case (sel)
            3'b100: begin
                p = longint'(sa) * longint'(sb);
                return {1'b1, p};
            end
            3'b101: begin
                pu = {32'd0, a} * {32'd0, b};
                return {1'b1, pu};
            end
            3'b110: begin
                if (b == 32'd0) return {1'b0, 64'd0};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'd0, 32'h8000_0000};
                q = sa / sb;
                r = sa - q * sb;
                return {1'b1, r, q};
            end
            3'b111: begin
                if (b == 32'd0) return {1'b0, 64'd0};
                qu = a / b;
                ru = a - qu * b;
                return {1'b1, ru, qu};
            end
            default: return {1'b0, 64'd0};
        endcase
    endfunction

    function automatic int model_cycles(input logic [2:0] sel);
        return sel[1] ? 10 : 5;
    endfunction

    task automatic test_reset();
        idle_inputs();
        do_reset();
        bus.d_is_md = 1'b1;
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%h want=0", bus.busy); end
        total++; if (bus.hi !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h want=0", bus.hi); end
        total++; if (bus.lo !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h want=0", bus.lo); end
        total++; if (bus.stall_req !== 1'b0) begin bad++; $display("FAIL reset_stall got=%h want=0", bus.stall_req); end
        total++; if (bus.rd_val !== 32'd0) begin bad++; $display("FAIL reset_rd got=%h want=0", bus.rd_val); end
        bus.d_is_md = 1'b0;
    endtask

    task automatic test_mult();
        int n;
        run_op(3'b100, 32'hFFFF_FFFF, 32'd2, n);
        total++; if (n != 5) begin bad++; $display("FAIL mult_busy got=%0d want=5", n); end
        total++; if (bus.hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi got=%h want=ffffffff", bus.hi); end
        total++; if (bus.lo !== 32'hFFFF_FFFE) begin bad++; $display("FAIL mult_lo got=%h want=fffffffe", bus.lo); end
        bus.md_sel = 3'b000;
        #1;
        total++; if (bus.rd_val !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_mfhi got=%h want=ffffffff", bus.rd_val); end
        run_op(3'b101, 32'hFFFF_FFFF, 32'd2, n);
        total++; if (n != 5) begin bad++; $display("FAIL multu_busy got=%0d want=5", n); end
        total++; if (bus.hi !== 32'd1) begin bad++; $display("FAIL multu_hi got=%h want=1", bus.hi); end
        total++; if (bus.lo !== 32'hFFFF_FFFE) begin bad++; $display("FAIL multu_lo got=%h want=fffffffe", bus.lo); end
    endtask

    task automatic test_div();
        int n;
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2, n);
        total++; if (n != 10) begin bad++; $display("FAIL div_busy got=%0d want=10", n); end
        total++; if (bus.lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_lo got=%h want=fffffffd", bus.lo); end
        total++; if (bus.hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_hi got=%h want=ffffffff", bus.hi); end
        run_op(3'b111, 32'd7, 32'd0, n);
        total++; if (n != 10) begin bad++; $display("FAIL divu0_busy got=%0d want=10", n); end
        total++; if (bus.lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL divu0_lo got=%h want=fffffffd", bus.lo); end
        total++; if (bus.hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divu0_hi got=%h want=ffffffff", bus.hi); end
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, n);
        total++; if (bus.lo !== 32'h8000_0000) begin bad++; $display("FAIL divovf_lo got=%h want=80000000", bus.lo); end
        total++; if (bus.hi !== 32'd0) begin bad++; $display("FAIL divovf_hi got=%h want=0", bus.hi); end
        run_op(3'b110, 32'd7, 32'hFFFF_FFFE, n);
        total++; if (bus.lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_negdiv_lo got=%h want=fffffffd", bus.lo); end
        total++; if (bus.hi !== 32'd1) begin bad++; $display("FAIL div_negdiv_hi got=%h want=1", bus.hi); end
    endtask

    task automatic test_mthi_mtlo();
        bus.md_en  = 1'b1;
        bus.md_sel = 3'b001;
        bus.rs_val = 32'h1234_5678;
        tick();
        bus.md_en  = 1'b0;
        bus.md_sel = 3'b000;
        #1;
        total++; if (bus.rd_val !== 32'h1234_5678) begin bad++; $display("FAIL mfhi got=%h want=12345678", bus.rd_val); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mthi_busy got=%h want=0", bus.busy); end
        bus.md_en  = 1'b1;
        bus.md_sel = 3'b011;
        bus.rs_val = 32'hCAFE_F00D;
        tick();
        bus.md_en  = 1'b0;
        bus.md_sel = 3'b010;
        #1;
        total++; if (bus.rd_val !== 32'hCAFE_F00D) begin bad++; $display("FAIL mflo got=%h want=cafef00d", bus.rd_val); end
        total++; if (bus.hi !== 32'h1234_5678) begin bad++; $display("FAIL mtlo_hi_kept got=%h want=12345678", bus.hi); end
        bus.md_sel = 3'b001;
        #1;
        total++; if (bus.rd_val !== 32'd0) begin bad++; $display("FAIL rd_other_sel got=%h want=0", bus.rd_val); end
        bus.md_sel = 3'b000;
    endtask

    task automatic test_stall();
        for (int d = 1; d >= 0; d--) begin
            bus.d_is_md = d[0];
            bus.md_en   = 1'b1;
            bus.md_sel  = 3'b100;
            bus.rs_val  = 32'd3;
            bus.rt_val  = 32'd4;
            #1;
            total++; if (bus.stall_req !== d[0]) begin bad++; $display("FAIL stall_start d=%0d got=%h want=%h", d, bus.stall_req, d[0]); end
            tick();
            bus.md_en  = 1'b0;
            bus.md_sel = 3'b000;
            for (int i = 0; i < 5; i++) begin
                #1;
                total++; if (bus.stall_req !== d[0] || bus.busy !== 1'b1) begin
                    bad++; $display("FAIL stall_busy d=%0d cyc=%0d got=%h/%h want=%h/1", d, i, bus.stall_req, bus.busy, d[0]);
                end
                tick();
            end
            total++; if (bus.stall_req !== 1'b0 || bus.busy !== 1'b0) begin
                bad++; $display("FAIL stall_after d=%0d got=%h/%h want=0/0", d, bus.stall_req, bus.busy);
            end
        end
        bus.d_is_md = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int n;
        start_op(3'b110, 32'd100, 32'd7);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%h want=0", bus.busy); end
        total++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin bad++; $display("FAIL midrst_hilo got=%h/%h want=0/0", bus.hi, bus.lo); end
        run_op(3'b100, 32'd3, 32'd4, n);
        total++; if (n != 5) begin bad++; $display("FAIL midrst_mult_busy got=%0d want=5", n); end
        total++; if (bus.lo !== 32'd12 || bus.hi !== 32'd0) begin bad++; $display("FAIL midrst_mult got=%h/%h want=0/c", bus.hi, bus.lo); end
    endtask

    task automatic test_random();
        logic [2:0]  sel;
        logic [31:0] a, b;
        logic        d;
        logic [64:0] exp;
        int          n;
        do_reset();
        m_hi = 32'd0;
        m_lo = 32'd0;
        for (int it = 0; it < 60; it++) begin
            sel = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            if ($urandom_range(0, 5) == 0) b = 32'd0;
            if ($urandom_range(0, 9) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if ($urandom_range(0, 7) == 0) b = 32'd1 + 32'($urandom_range(0, 15));
            d = 1'($urandom_range(0, 1));
            bus.d_is_md = d;
            bus.md_en   = 1'b1;
            bus.md_sel  = sel;
            bus.rs_val  = a;
            bus.rt_val  = b;
            #1;
            total++; if (bus.stall_req !== (d & sel[2])) begin bad++; $display("FAIL rnd_stall0 it=%0d got=%h want=%h", it, bus.stall_req, d & sel[2]); end
            if (sel == 3'b000 || sel == 3'b010) begin
                total++; if (bus.rd_val !== (sel[1] ? m_lo : m_hi)) begin
                    bad++; $display("FAIL rnd_mf it=%0d got=%h want=%h", it, bus.rd_val, sel[1] ? m_lo : m_hi);
                end
            end
            tick();
            bus.md_en = 1'b0;
            if (sel[2]) begin
                exp = model_op(sel, a, b);
                n = 0;
                while (bus.busy === 1'b1 && n < 40) begin
                    // A stray request while busy must be ignored.
                    if (n == 1) begin
                        bus.md_en  = 1'b1;
                        bus.md_sel = 3'($urandom_range(0, 7));
                        bus.rs_val = $urandom;
                        bus.rt_val = $urandom;
                    end else begin
                        bus.md_en = 1'b0;
                    end
                    #1;
                    total++; if (bus.stall_req !== d) begin bad++; $display("FAIL rnd_stall it=%0d cyc=%0d got=%h want=%h", it, n, bus.stall_req, d); end
                    n++;
                    tick();
                end
                bus.md_en = 1'b0;
                total++; if (n != model_cycles(sel)) begin bad++; $display("FAIL rnd_busy it=%0d got=%0d want=%0d", it, n, model_cycles(sel)); end
                if (exp[64]) begin
                    m_hi = exp[63:32];
                    m_lo = exp[31:0];
                end
            end else begin
                if (sel == 3'b001) m_hi = a;
                if (sel == 3'b011) m_lo = a;
                total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rnd_mt_busy it=%0d got=%h want=0", it, bus.busy); end
            end
            total++; if (bus.hi !== m_hi || bus.lo !== m_lo) begin
                bad++; $display("FAIL rnd_hilo it=%0d sel=%0d a=%h b=%h got=%h/%h want=%h/%h", it, sel, a, b, bus.hi, bus.lo, m_hi, m_lo);
            end
        end
        idle_inputs();
    endtask

`ifdef MDU_ABORT_EN
    task automatic test_abort();
        bus.md_en = 1'b1;
        bus.md_sel = 3'b001;
        bus.rs_val = 32'hA5A5_A5A5;
        tick();
        bus.md_sel = 3'b011;
        tick();
        start_op(3'b100, 32'd9, 32'd9);
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%h want=0", bus.busy); end
        repeat (6) tick();
        total++; if (bus.hi !== 32'hA5A5_A5A5 || bus.lo !== 32'hA5A5_A5A5) begin
            bad++; $display("FAIL abort_hilo got=%h/%h want=a5a5a5a5", bus.hi, bus.lo);
        end
        bus.abort = 1'b1;
        start_op(3'b110, 32'd9, 32'd3);
        bus.abort = 1'b0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_start_busy got=%h want=0", bus.busy); end
        repeat (11) tick();
        total++; if (bus.lo !== 32'hA5A5_A5A5) begin bad++; $display("FAIL abort_start_lo got=%h want=a5a5a5a5", bus.lo); end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_mult();
        test_div();
        test_mthi_mtlo();
        test_stall();
        test_reset_mid_run();
`ifdef MDU_ABORT_EN
        test_abort();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Multi-cycle multiply/divide controller that owns the HI/LO register pair.
- Sits in the E stage beside the ALU and is driven by the decoder's ISMULTDIV and MULTSel outputs.
- Sequences mult/multu/div/divu over fixed latencies, services mthi/mtlo/mfhi/mflo, and raises a stall request to the hazard unit.
- Stall request fires while a D-stage mult/div-class instruction would collide with a busy unit.

Parameters:
- MULT_CYCLES, 5, cycles from mult/multu start until HI/LO commit (≥1).
- DIV_CYCLES, 10, cycles from div/divu start until HI/LO commit (≥1).
- CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- md_en  in  1  E-stage instruction is a valid, non-flushed mult/div-class instruction
- md_sel  in  3  MULTSel {funct[3],funct[1:0]}: 000 mfhi, 001 mthi, 010 mflo, 011 mtlo, 100 mult, 101 multu, 110 div, 111 divu
- rs_val  in  32  forwarded rs operand (E stage)
- rt_val  in  32  forwarded rt operand (E stage)
- d_is_md  in  1  D-stage instruction is mult/div-class (ISMULTDIV in D)
- busy  out  1  operation in flight
- stall_req  out  1  stall D stage this cycle
- rd_val  out  32  HI when md_sel=000, LO when md_sel=010, else 0 (combinational)
- hi  out  32  architectural HI
- lo  out  32  architectural LO
- abort  in  1  present only with MDU_ABORT_EN

Behaviour:
- Clocking and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: HI=0, LO=0, busy=0, counter=0, state=IDLE, pending result=0.
- States: IDLE, RUN.
- IDLE, md_en & md_sel[2]=1 (start):
  - Compute the 64-bit result from rs_val/rt_val into pending regs.
  - Load counter with MULT_CYCLES-1 or DIV_CYCLES-1; go to RUN.
  - busy=1 from the next cycle.
- RUN: counter decrements each cycle. At counter==0: HI/LO <= pending, state=IDLE, busy=0 on the following cycle.
  - mult result is visible to mfhi exactly MULT_CYCLES+1 cycles after the start cycle.
- Arithmetic:
  - mult: signed 32x32 -> {HI,LO}. multu: unsigned.
  - div: LO=quotient, HI=remainder, both truncated toward zero, remainder takes the dividend's sign. divu: unsigned.
- Divide by zero: HI/LO retain old values; the full DIV_CYCLES busy period still runs.
- Signed overflow (0x80000000 / -1): LO=0x80000000, HI=0.
- mthi/mtlo (md_en & sel 001/011, IDLE only): HI or LO <= rs_val at the next edge; no busy period.
- mfhi/mflo: rd_val reads the current HI/LO combinationally. A same-cycle mthi/mtlo is not bypassed; the hazard unit separates them.
- stall_req = d_is_md & (busy | (md_en & md_sel[2])).
- The hazard unit guarantees that md_en never asserts while busy. If it does anyway, ignore md_en; the in-flight operation is unaffected.
- reset mid-RUN: immediate return to reset values; pending result discarded.

Optional Feature:
- Macro: MDU_ABORT_EN.
- Defined: abort port exists. abort=1 in RUN returns to IDLE next edge, busy=0, HI/LO unchanged, pending discarded. abort in the same cycle as a start suppresses the start. Used on exception entry, for an instruction killed after E.
- Undefined: no abort port; an in-flight operation always completes and commits.

Decomposition:
- Package mdu_pkg:
  - MULTSel encodings as localparams (MD_MFHI … MD_DIVU).
  - IDLE/RUN state encoding.
  - Default MULT_CYCLES/DIV_CYCLES.
- Sub-module mdu_arith: combinational 64-bit signed/unsigned multiply and divide, including the divide-by-zero and overflow rules above. It returns {hi,lo,valid}; valid=0 on divide by zero.
- mdu_sequencer holds the FSM, counter, pending regs and HI/LO.

Test Plan:
- Reset, then mult rs=0xFFFFFFFF (-1), rt=2 -> busy high for 5 cycles; on the 6th cycle HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu with the same operands -> HI=1, LO=0xFFFFFFFE.
- div rs=-7, rt=2 -> busy 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu rs=7, rt=0 -> busy 10 cycles, HI/LO unchanged.
- mthi rs=0x12345678, next cycle mfhi -> rd_val=0x12345678, no busy; mtlo leaves HI intact.
- mult in E with d_is_md=1 -> stall_req=1 in the start cycle and for all 5 busy cycles, 0 after; with d_is_md=0 -> stall_req=0 throughout.
- reset asserted on the 3rd cycle of div -> busy=0, HI=LO=0 at the next edge; a new mult then runs normally.
- MDU_ABORT_EN: abort on the 2nd busy cycle of mult with HI=LO=0xA5A5A5A5 -> busy=0 next cycle, HI/LO still 0xA5A5A5A5. abort together with start -> no busy.
